// File: rtl/mem_access_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : mem_access_pkg                                         |
// | Description : Shared types for the load/store memory access block:  |
// |               access size encodings, controller states, default     |
// |               memory size and the request legality check.           |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package mem_access_pkg;

  localparam int unsigned MEM_BYTES_DEFAULT = 128;

  typedef enum logic [1:0] {
    SZ_BYTE    = 2'b00,
    SZ_HALF    = 2'b01,
    SZ_WORD    = 2'b10,
    SZ_ILLEGAL = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_READ  = 2'b01,
    ST_WRITE = 2'b10,
    ST_RESP  = 2'b11
  } state_e;

  // A request is rejected when its size is illegal, it is misaligned for its
  // size, or any part of it would start beyond the attached memory.
  function automatic logic access_err(input size_e       size,
                                      input logic [31:0] addr,
                                      input int unsigned mem_bytes);
    logic err;
    err = (addr >= mem_bytes);
    case (size)
      SZ_HALF:    err = err | addr[0];
      SZ_WORD:    err = err | (addr[1:0] != 2'b00);
      SZ_ILLEGAL: err = 1'b1;
      default:    ;
    endcase
    return err;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_access_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : mem_access_ctrl_if                                     |
// | Description : Pipeline request/response handshake plus the data     |
// |               memory bus of the memory access controller.           |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
interface mem_access_ctrl_if;

  // pipeline side
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  // data memory side (RD/WR active low)
  logic [31:0] DAddr;
  logic [31:0] DataIn;
  logic        RD;
  logic        WR;
  logic [31:0] DataOut;

  // controller view
  modport slave (
    input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output DAddr, DataIn, RD, WR,
    input  DataOut
  );

  // pipeline + memory view
  modport master (
    output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  DAddr, DataIn, RD, WR,
    output DataOut
  );

endinterface
`default_nettype wire

// File: rtl/mem_lane_align.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : mem_lane_align                                         |
// | Description : Big-endian lane handling. Extracts and extends the     |
// |               addressed byte/halfword of a memory word for loads and |
// |               merges store data into the addressed lanes.           |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module mem_lane_align
  import mem_access_pkg::*;
(
  input  wire logic [31:0] rword_i,   // word read from memory
  input  wire logic [15:0] wdata_i,   // right-aligned store data
  input  wire logic [1:0]  off_i,     // byte offset within the word
  input  size_e            size_i,
  input  wire logic        signed_i,
  output logic      [31:0] load_o,    // extended load result
  output logic      [31:0] merge_o    // rword_i with addressed lanes replaced
);

  // Offset 0 is the most significant lane, so the shift is (3-off)*8 for
  // bytes and (off[1] ? 0 : 16) for halfwords.
  logic [4:0]  sh_b;
  logic [4:0]  sh_h;
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  assign sh_b   = {~off_i, 3'b000};
  assign sh_h   = {~off_i[1], 4'b0000};
  assign byte_v = 8'(rword_i >> sh_b);
  assign half_v = 16'(rword_i >> sh_h);

  // Select extraction/merge by access size; words pass straight through.
  always_comb begin
    load_o  = rword_i;
    merge_o = rword_i;
    case (size_i)
      SZ_BYTE: begin
        load_o  = {{24{signed_i & byte_v[7]}}, byte_v};
        merge_o = (rword_i & ~(32'h0000_00FF << sh_b))
                | ({24'h0, wdata_i[7:0]} << sh_b);
      end
      SZ_HALF: begin
        load_o  = {{16{signed_i & half_v[15]}}, half_v};
        merge_o = (rword_i & ~(32'h0000_FFFF << sh_h))
                | ({16'h0, wdata_i} << sh_h);
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_access_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : mem_access_ctrl                                        |
// | Description : Load/store controller between a pipeline request port  |
// |               and a word-wide data memory with active-low RD/WR.    |
// |               Sub-word stores use read-modify-write.                |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module mem_access_ctrl
  import mem_access_pkg::*;
#(
  parameter int unsigned MEM_BYTES = MEM_BYTES_DEFAULT
)(
  input  wire logic        CLK,
  input  wire logic        Reset,
  mem_access_ctrl_if.slave bus
);

  state_e      state_q, state_d;
  logic        we_q;
  size_e       size_q;
  logic        signed_q;
  logic [1:0]  off_q;
  logic [15:0] wdata_q;
  logic [29:0] daddr_q;
  logic [31:0] datain_q;
  logic        rd_q, wr_q;
  logic        resp_valid_q, resp_err_q;
  logic [31:0] resp_rdata_q;

  size_e       req_size;
  logic        accept;
  logic        req_err;
  logic [31:0] load_data;
  logic [31:0] merged;

  assign req_size = size_e'(bus.req_size);
  assign accept   = bus.req_valid && (state_q == ST_IDLE);
  assign req_err  = access_err(req_size, bus.req_addr, MEM_BYTES);

  mem_lane_align u_align (
    .rword_i  (bus.DataOut),
    .wdata_i  (wdata_q),
    .off_i    (off_q),
    .size_i   (size_q),
    .signed_i (signed_q),
    .load_o   (load_data),
    .merge_o  (merged)
  );

  // State register.
  always_ff @(posedge CLK) begin
    if (Reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state: loads and sub-word stores read first; word stores write
  // directly; rejected requests go straight to the response.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (req_err)                                state_d = ST_RESP;
          else if (bus.req_we && req_size == SZ_WORD) state_d = ST_WRITE;
          else                                        state_d = ST_READ;
        end
      end
      ST_READ:  state_d = we_q ? ST_WRITE : ST_RESP;
      ST_WRITE: state_d = ST_RESP;
      ST_RESP:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Request latch, registered memory strobes/address/data and response.
  // Strobes follow the next state so RD/WR are low exactly in READ/WRITE.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      we_q         <= 1'b0;
      size_q       <= SZ_BYTE;
      signed_q     <= 1'b0;
      off_q        <= 2'b00;
      wdata_q      <= 16'h0;
      daddr_q      <= 30'h0;
      datain_q     <= 32'h0;
      rd_q         <= 1'b1;
      wr_q         <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= 32'h0;
    end else begin
      rd_q         <= (state_d != ST_READ);
      wr_q         <= (state_d != ST_WRITE);
      resp_valid_q <= (state_d == ST_RESP);
      resp_err_q   <= accept && req_err;
      resp_rdata_q <= (state_q == ST_READ && !we_q) ? load_data : 32'h0;
      if (accept) begin
        we_q     <= bus.req_we;
        size_q   <= req_size;
        signed_q <= bus.req_signed;
        off_q    <= bus.req_addr[1:0];
        wdata_q  <= bus.req_wdata[15:0];
        daddr_q  <= bus.req_addr[31:2];
        if (bus.req_we && req_size == SZ_WORD)
          datain_q <= bus.req_wdata;
      end
      // DataOut is captured at the edge that ends READ.
      if (state_q == ST_READ && we_q)
        datain_q <= merged;
    end
  end

  assign bus.req_ready  = (state_q == ST_IDLE);
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.DAddr      = {2'b00, daddr_q};
  assign bus.DataIn     = datain_q;
  assign bus.RD         = rd_q;
  assign bus.WR         = wr_q;

endmodule
`default_nettype wire

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 SHALL have parameter MEM_BYTES, default 128; size of the attached data memory in bytes.
REQ-002 SHALL have port CLK  in  1  system clock; all state changes on the rising edge.
REQ-003 SHALL have port Reset  in  1  synchronous, active-high reset.
REQ-004 SHALL have port req_valid  in  1  pipeline access request.
REQ-005 SHALL have port req_ready  out  1  block can accept a request.
REQ-006 SHALL have port req_we  in  1  1 = store, 0 = load.
REQ-007 SHALL have port req_size  in  2  00 byte, 01 halfword, 10 word, 11 illegal.
REQ-008 SHALL have port req_signed  in  1  sign-extend load data; ignored for stores.
REQ-009 SHALL have port req_addr  in  32  byte address.
REQ-010 SHALL have port req_wdata  in  32  store data, right-aligned for byte and halfword.
REQ-011 SHALL have port resp_valid  out  1  one-cycle completion pulse.
REQ-012 SHALL have port resp_rdata  out  32  load result; 0 for stores and errors.
REQ-013 SHALL have port resp_err  out  1  access rejected; valid with resp_valid.
REQ-014 SHALL have port DAddr  out  32  word index to memory, equal to req_addr[31:2].
REQ-015 SHALL have port DataIn  out  32  write word to memory.
REQ-016 SHALL have port RD  out  1  active-low memory read enable.
REQ-017 SHALL have port WR  out  1  active-low memory write enable; memory commits on the falling CLK edge.
REQ-018 SHALL have port DataOut  in  32  combinational read word from memory.

Function
REQ-019 SHALL implement FSM states IDLE, READ, WRITE, RESP; req_ready = 1 only in IDLE.
REQ-020 SHALL, on req_valid && req_ready, latch we, size, signed, addr and wdata.
REQ-021 SHALL flag an error for: size 11; half with addr[0]=1; word with addr[1:0]!=0; addr >= MEM_BYTES.
REQ-022 SHALL transition on error IDLE->RESP with resp_err=1 and no memory access (RD and WR stay 1).
REQ-023 SHALL sequence a load as IDLE->READ->RESP; resp_valid 2 cycles after acceptance.
REQ-024 SHALL sequence a word store as IDLE->WRITE->RESP with DataIn = wdata.
REQ-025 SHALL sequence a byte or halfword store as IDLE->READ->WRITE->RESP; DataIn = DataOut sampled in READ with the addressed lanes replaced.
REQ-026 SHALL drive RD, WR from registers: RD=0 for exactly the READ cycle, WR=0 for exactly the WRITE cycle, otherwise 1.
REQ-027 SHALL never assert RD=0 and WR=0 in the same cycle.
REQ-028 SHALL hold DAddr stable from the cycle after acceptance through RESP.
REQ-029 SHALL use big-endian lanes: byte offset 0 = bits 31:24, 3 = bits 7:0; halfword offset 0 = bits 31:16, offset 2 = bits 15:0.
REQ-030 SHALL zero-extend or sign-extend load data to 32 bits per latched signed.
REQ-031 SHALL capture DataOut at the rising edge ending READ.
REQ-032 SHALL assert resp_valid for exactly one cycle in RESP with no backpressure, then return to IDLE.
REQ-033 SHALL ignore req_valid outside IDLE; a request held high is accepted on the next IDLE cycle.

Reset
REQ-034 SHALL reset to: state IDLE, req_ready 1, RD 1, WR 1, resp_valid 0, resp_rdata 0, resp_err 0, DAddr 0, DataIn 0.
REQ-035 SHALL abandon any in-flight access when Reset is sampled; no response is issued.
REQ-036 SHALL, when Reset is sampled at the edge that would enter WRITE, produce no WR=0 cycle and no memory write.

Structure
REQ-037 SHALL place size encodings, state enumeration and MEM_BYTES default in shared package mem_access_pkg.
REQ-038 SHALL isolate lane extract/extend and store merge in combinational sub-module mem_lane_align.

Verification (bench instantiates the team data memory as responder)
REQ-039 SHALL cover: store word 0x11223344 @0x08, then load word @0x08 -> DAddr=2, one WR=0 cycle, resp_rdata 0x11223344.
REQ-040 SHALL cover: store byte 0xAB @0x09, then load word @0x08 -> one RD=0 cycle then one WR=0 cycle, resp_rdata 0x11AB3344.
REQ-041 SHALL cover loads after REQ-040 -> signed byte @0x09 gives 0xFFFFFFAB; unsigned byte gives 0x000000AB; signed half @0x0A gives 0x00003344.
REQ-042 SHALL cover: word load @0x06, then word load @0x80 -> each resp_err=1 one cycle after acceptance, RD and WR stay 1.
REQ-043 SHALL cover: Reset asserted during READ of a halfword store -> no WR=0 cycle, memory unchanged, req_ready=1 after reset.
REQ-044 SHALL cover: req_valid held high across back-to-back loads -> accepted in every IDLE cycle, one resp_valid pulse per request.
